// File: rtl/spi_cmd_pkg.sv
// Purpose: shared constants, field widths, FSM state encoding and command layout for the SPI command loader.
// Latency: none (declarations only).
// Backpressure: none.
`timescale 1ns/1ps
package spi_cmd_pkg;

  // Default frame header bytes
  localparam logic [7:0] HDR_CMD_DEF  = 8'hA5;
  localparam logic [7:0] HDR_TIME_DEF = 8'h5A;

  // Payload lengths in bytes, excluding header and checksum
  localparam int CMD_LEN  = 43;
  localparam int TIME_LEN = 8;
  localparam int CMD_BITS = CMD_LEN * 8;

  // Index of the last payload byte for each frame type
  localparam logic [5:0] CMD_LAST  = 6'(CMD_LEN - 1);
  localparam logic [5:0] TIME_LAST = 6'(TIME_LEN - 1);

  // Field widths
  localparam int FREQ_W = 48;
  localparam int RATE_W = 32;
  localparam int TIME_W = 64;
  localparam int N_W    = 16;
  localparam int TYPE_W = 2;
  localparam int INTV_W = 32;
  localparam int ERR_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CHK,
    WAIT_CS,
    DISCARD,
    COMMIT,
    ERROR
  } state_t;

  // Command payload as it arrives on the wire: first byte lands in the MSBs
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] freq_step;
    logic [RATE_W-1:0] freq_rate;
    logic [TIME_W-1:0] time_start;
    logic [N_W-1:0]    n_impulse;
    logic [7:0]        type_byte;
    logic [INTV_W-1:0] ti;
    logic [INTV_W-1:0] tp;
    logic [INTV_W-1:0] tblank1;
    logic [INTV_W-1:0] tblank2;
  } cmd_t;

  // Saturating increment for the rejected-frame counter
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Purpose: multi-stage synchroniser for an asynchronous pin, with rise/fall strobes on the synchronised level.
// Latency: a pin edge shows up as a one-cycle strobe STAGES clock edges later.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              lvl_d;

  // Shift the pin through the synchroniser and keep the previous synchronised level.
  // Resetting to 0 means a reset taken while CS_N is low produces no false falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      lvl_d <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], din};
      lvl_d <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~lvl_d;
  assign fall = ~sync[STAGES-1] & lvl_d;

endmodule

// File: rtl/spi_cmd_loader.sv
// Purpose: receives SPI mode-0 command/time frames, checks header, length and XOR checksum, then loads outputs.
// Latency: SPI_WR and fields update SYNC_STAGES+2 CLK edges after the CS_N pin rises.
// Backpressure: none; the SPI master cannot be stalled, bad frames are counted and dropped.
`timescale 1ns/1ps
module spi_cmd_loader
  import spi_cmd_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HDR_CMD     = HDR_CMD_DEF,
  parameter logic [7:0] HDR_TIME    = HDR_TIME_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCK,
  input  logic              CS_N,
  input  logic              MOSI,
  input  logic              SYS_TIME_UPDATE_OK,
  output logic [FREQ_W-1:0] FREQ,
  output logic [FREQ_W-1:0] FREQ_STEP,
  output logic [RATE_W-1:0] FREQ_RATE,
  output logic [TIME_W-1:0] TIME_START,
  output logic [N_W-1:0]    N_impulse,
  output logic [TYPE_W-1:0] TYPE_impulse,
  output logic [INTV_W-1:0] Interval_Ti,
  output logic [INTV_W-1:0] Interval_Tp,
  output logic [INTV_W-1:0] Tblank1,
  output logic [INTV_W-1:0] Tblank2,
  output logic              SPI_WR,
  output logic [TIME_W-1:0] TIME_INIT,
  output logic              SYS_TIME_UPDATE,
  output logic              FRAME_ERR,
  output logic [ERR_W-1:0]  ERR_CNT
);

  state_t state, state_nx;

  logic                   sck_rise, sck_fall;
  logic                   cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  logic [2:0]             bit_cnt;
  logic [5:0]             byte_cnt;
  logic [6:0]             sh;
  logic [7:0]             xor_acc;
  logic                   len_err;
  logic                   is_time;
  logic [CMD_BITS-1:0]    stage;

  logic                   in_byte;
  logic                   samp;
  logic                   byte_done;
  logic [7:0]             new_byte;
  logic                   hdr_ok;
  logic                   last_payload;
  logic                   frame_ok;
  cmd_t                   cmd_w;
  logic                   unused_bits;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (CLK),
    .rst  (RESET),
    .din  (SCK),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (CLK),
    .rst  (RESET),
    .din  (CS_N),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI gets the same depth as SCK so data and its sampling edge stay aligned
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign mosi_s       = mosi_sync[SYNC_STAGES-1];
  assign in_byte      = (state == HDR) || (state == PAYLOAD) || (state == CHK);
  assign samp         = sck_rise && in_byte;
  assign byte_done    = samp && (bit_cnt == 3'd7);
  assign new_byte     = {sh, mosi_s};
  assign hdr_ok       = (new_byte == HDR_CMD) || (new_byte == HDR_TIME);
  assign last_payload = (byte_cnt == (is_time ? TIME_LAST : CMD_LAST));
  // XOR over header, payload and checksum byte is zero for an intact frame
  assign frame_ok     = (xor_acc == 8'h00) && !len_err;
  assign cmd_w        = stage;
  // TYPE byte bits [7:2] and SCK falling edges carry no information here
  assign unused_bits  = ^{cmd_w.type_byte[7:2], sck_fall};

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: any CS_N rise outside WAIT_CS is a malformed frame
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cs_fall) state_nx = HDR;
      end
      HDR: begin
        if (cs_rise)        state_nx = ERROR;
        else if (byte_done) state_nx = hdr_ok ? PAYLOAD : DISCARD;
      end
      PAYLOAD: begin
        if (cs_rise)                        state_nx = ERROR;
        else if (byte_done && last_payload) state_nx = CHK;
      end
      CHK: begin
        if (cs_rise)        state_nx = ERROR;
        else if (byte_done) state_nx = WAIT_CS;
      end
      WAIT_CS: begin
        if (cs_rise) state_nx = frame_ok ? COMMIT : ERROR;
      end
      DISCARD: begin
        if (cs_rise) state_nx = ERROR;
      end
      COMMIT:  state_nx = IDLE;
      ERROR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bit/byte counting, checksum accumulation and payload staging
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= 6'd0;
      sh       <= 7'd0;
      xor_acc  <= 8'd0;
      len_err  <= 1'b0;
      is_time  <= 1'b0;
      stage    <= '0;
    end else begin
      if ((state == IDLE) && cs_fall) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 6'd0;
        xor_acc  <= 8'd0;
        len_err  <= 1'b0;
        is_time  <= 1'b0;
      end
      if (samp) begin
        sh      <= new_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        xor_acc <= xor_acc ^ new_byte;
        if (state == HDR) begin
          is_time <= (new_byte == HDR_TIME);
        end
        if (state == PAYLOAD) begin
          stage    <= {stage[CMD_BITS-9:0], new_byte};
          byte_cnt <= byte_cnt + 6'd1;
        end
      end
      // Clock edges after the checksum byte mean the frame is too long
      if (sck_rise && (state == WAIT_CS)) begin
        len_err <= 1'b1;
      end
    end
  end

  // Output registers: written only on commit or reject, strobes default low
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FREQ            <= '0;
      FREQ_STEP       <= '0;
      FREQ_RATE       <= '0;
      TIME_START      <= '0;
      N_impulse       <= '0;
      TYPE_impulse    <= '0;
      Interval_Ti     <= '0;
      Interval_Tp     <= '0;
      Tblank1         <= '0;
      Tblank2         <= '0;
      SPI_WR          <= 1'b0;
      TIME_INIT       <= '0;
      SYS_TIME_UPDATE <= 1'b0;
      FRAME_ERR       <= 1'b0;
      ERR_CNT         <= '0;
    end else begin
      SPI_WR    <= 1'b0;
      FRAME_ERR <= 1'b0;
      if ((state == COMMIT) && !is_time) begin
        FREQ         <= cmd_w.freq;
        FREQ_STEP    <= cmd_w.freq_step;
        FREQ_RATE    <= cmd_w.freq_rate;
        TIME_START   <= cmd_w.time_start;
        N_impulse    <= cmd_w.n_impulse;
        TYPE_impulse <= cmd_w.type_byte[TYPE_W-1:0];
        Interval_Ti  <= cmd_w.ti;
        Interval_Tp  <= cmd_w.tp;
        Tblank1      <= cmd_w.tblank1;
        Tblank2      <= cmd_w.tblank2;
        SPI_WR       <= 1'b1;
      end
      // A time commit outranks a simultaneous acknowledge
      if ((state == COMMIT) && is_time) begin
        TIME_INIT       <= stage[TIME_W-1:0];
        SYS_TIME_UPDATE <= 1'b1;
      end else if (SYS_TIME_UPDATE_OK) begin
        SYS_TIME_UPDATE <= 1'b0;
      end
      if (state == ERROR) begin
        FRAME_ERR <= 1'b1;
        ERR_CNT   <= sat_inc(ERR_CNT);
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_loader.sv
// Purpose: directed self-checking bench for spi_cmd_loader.
// Latency: checks the commit strobe position relative to the CS_N pin rise.
// Backpressure: none.
`timescale 1ns/1ps
module tb_spi_cmd_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SCK = 1'b0;
  logic        CS_N = 1'b1;
  logic        MOSI = 1'b0;
  logic        SYS_TIME_UPDATE_OK = 1'b0;
  logic [47:0] FREQ, FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [1:0]  TYPE_impulse;
  logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic        SPI_WR;
  logic [63:0] TIME_INIT;
  logic        SYS_TIME_UPDATE;
  logic        FRAME_ERR;
  logic [7:0]  ERR_CNT;

  int compared = 0;
  int mismatched = 0;
  int wr_pulses = 0;
  int err_pulses = 0;

  logic [7:0] frm [$];

  // Test 1 payload; PL_T6 differs only in ignored TYPE byte bits
  localparam logic [343:0] PL = {48'h001000000000, 48'h000000100000, 32'h00000100,
                                 64'h00000000000012C0, 16'd2, 8'h01,
                                 32'h00001800, 32'h00001800, 32'h00000180, 32'h00000180};
  localparam logic [343:0] PL_T6 = {48'h001000000000, 48'h000000100000, 32'h00000100,
                                    64'h00000000000012C0, 16'd2, 8'hFD,
                                    32'h00001800, 32'h00001800, 32'h00000180, 32'h00000180};

  spi_cmd_loader dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .SCK                (SCK),
    .CS_N               (CS_N),
    .MOSI               (MOSI),
    .SYS_TIME_UPDATE_OK (SYS_TIME_UPDATE_OK),
    .FREQ               (FREQ),
    .FREQ_STEP          (FREQ_STEP),
    .FREQ_RATE          (FREQ_RATE),
    .TIME_START         (TIME_START),
    .N_impulse          (N_impulse),
    .TYPE_impulse       (TYPE_impulse),
    .Interval_Ti        (Interval_Ti),
    .Interval_Tp        (Interval_Tp),
    .Tblank1            (Tblank1),
    .Tblank2            (Tblank2),
    .SPI_WR             (SPI_WR),
    .TIME_INIT          (TIME_INIT),
    .SYS_TIME_UPDATE    (SYS_TIME_UPDATE),
    .FRAME_ERR          (FRAME_ERR),
    .ERR_CNT            (ERR_CNT)
  );

  always #10 CLK = ~CLK;

  // Count strobe cycles, sampled on the inactive edge
  always @(negedge CLK) begin
    if (SPI_WR)    wr_pulses++;
    if (FRAME_ERR) err_pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string pre);
    chk({pre, "_freq"},       64'(FREQ),         64'h001000000000);
    chk({pre, "_freq_step"},  64'(FREQ_STEP),    64'h000000100000);
    chk({pre, "_freq_rate"},  64'(FREQ_RATE),    64'h100);
    chk({pre, "_time_start"}, TIME_START,        64'h12C0);
    chk({pre, "_n"},          64'(N_impulse),    64'd2);
    chk({pre, "_type"},       64'(TYPE_impulse), 64'd1);
    chk({pre, "_ti"},         64'(Interval_Ti),  64'h1800);
    chk({pre, "_tp"},         64'(Interval_Tp),  64'h1800);
    chk({pre, "_tb1"},        64'(Tblank1),      64'h180);
    chk({pre, "_tb2"},        64'(Tblank2),      64'h180);
  endtask

  task automatic mk_cmd(input logic [343:0] pl, input logic [7:0] flip);
    logic [7:0] x;
    logic [7:0] b;
    frm.delete();
    frm.push_back(8'hA5);
    x = 8'hA5;
    for (int i = 0; i < 43; i++) begin
      b = pl[343-8*i -: 8];
      frm.push_back(b);
      x = x ^ b;
    end
    frm.push_back(x ^ flip);
  endtask

  task automatic mk_time(input logic [63:0] t);
    logic [7:0] x;
    logic [7:0] b;
    frm.delete();
    frm.push_back(8'h5A);
    x = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      b = t[63-8*i -: 8];
      frm.push_back(b);
      x = x ^ b;
    end
    frm.push_back(x);
  endtask

  // SCK = CLK/8: 80 ns low, 80 ns high, mode 0, MSB first
  task automatic send_bits();
    for (int k = 0; k < frm.size(); k++) begin
      for (int i = 7; i >= 0; i--) begin
        MOSI = frm[k][i];
        #80 SCK = 1'b1;
        #80 SCK = 1'b0;
      end
    end
  endtask

  // Full frame; CS_N rises on a falling CLK edge so commit timing is predictable
  task automatic send_frame();
    CS_N = 1'b0;
    #200;
    send_bits();
    #100;
    @(negedge CLK);
    CS_N = 1'b1;
  endtask

  task automatic settle();
    repeat (12) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    #25;
    chk("rst_freq", 64'(FREQ), 64'd0);
    chk("rst_spi_wr", 64'(SPI_WR), 64'd0);
    chk("rst_frame_err", 64'(FRAME_ERR), 64'd0);
    chk("rst_err_cnt", 64'(ERR_CNT), 64'd0);
    chk("rst_sys_time_update", 64'(SYS_TIME_UPDATE), 64'd0);
    chk("rst_time_init", TIME_INIT, 64'd0);
    #20 RESET = 1'b0;
    repeat (5) @(posedge CLK);

    // 1: valid CMD frame, strobe SYNC_STAGES+2 = 4 edges after CS_N rise
    mk_cmd(PL, 8'h00);
    send_frame();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("t1_wr_early", 64'(SPI_WR), 64'd0);
    @(negedge CLK);
    chk("t1_wr_latency", 64'(SPI_WR), 64'd1);
    chk("t1_frame_err", 64'(FRAME_ERR), 64'd0);
    check_fields("t1");
    @(negedge CLK);
    chk("t1_wr_width", 64'(SPI_WR), 64'd0);
    settle();
    chk("t1_wr_pulses", 64'(wr_pulses), 64'd1);
    chk("t1_err_pulses", 64'(err_pulses), 64'd0);

    // 2: checksum bit 0 flipped
    mk_cmd(PL, 8'h01);
    send_frame();
    settle();
    chk("t2_err_pulses", 64'(err_pulses), 64'd1);
    chk("t2_err_cnt", 64'(ERR_CNT), 64'd1);
    chk("t2_wr_pulses", 64'(wr_pulses), 64'd1);
    check_fields("t2");

    // 3: truncated after 20 bytes, then a 46-byte frame
    mk_cmd(PL, 8'h00);
    frm = frm[0:19];
    send_frame();
    settle();
    chk("t3_short_err_pulses", 64'(err_pulses), 64'd2);
    mk_cmd(PL, 8'h00);
    frm.push_back(8'h00);
    send_frame();
    settle();
    chk("t3_long_err_pulses", 64'(err_pulses), 64'd3);
    chk("t3_err_cnt", 64'(ERR_CNT), 64'd3);
    chk("t3_wr_pulses", 64'(wr_pulses), 64'd1);

    // 4: TIME frame, then acknowledge later; then acknowledge coincident with commit
    mk_time(64'h0);
    send_frame();
    settle();
    chk("t4_stu_set", 64'(SYS_TIME_UPDATE), 64'd1);
    chk("t4_time_init", TIME_INIT, 64'h0);
    chk("t4_wr_pulses", 64'(wr_pulses), 64'd1);
    repeat (100) @(posedge CLK);
    #1;
    chk("t4_stu_hold", 64'(SYS_TIME_UPDATE), 64'd1);
    @(negedge CLK);
    SYS_TIME_UPDATE_OK = 1'b1;
    @(negedge CLK);
    SYS_TIME_UPDATE_OK = 1'b0;
    chk("t4_stu_cleared", 64'(SYS_TIME_UPDATE), 64'd0);
    mk_time(64'h0123456789ABCDEF);
    send_frame();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    SYS_TIME_UPDATE_OK = 1'b1;
    @(negedge CLK);
    SYS_TIME_UPDATE_OK = 1'b0;
    chk("t4_commit_wins", 64'(SYS_TIME_UPDATE), 64'd1);
    chk("t4_time_init2", TIME_INIT, 64'h0123456789ABCDEF);
    settle();
    chk("t4_stu_still_set", 64'(SYS_TIME_UPDATE), 64'd1);
    chk("t4_err_pulses", 64'(err_pulses), 64'd3);

    // 5: unknown header, then saturate the error counter
    frm.delete();
    frm.push_back(8'h33);
    send_frame();
    settle();
    chk("t5_err_pulses", 64'(err_pulses), 64'd4);
    chk("t5_err_cnt", 64'(ERR_CNT), 64'd4);
    for (int n = 0; n < 256; n++) begin
      send_frame();
      repeat (8) @(posedge CLK);
    end
    settle();
    chk("t5_err_cnt_sat", 64'(ERR_CNT), 64'hFF);
    chk("t5_err_pulses_sat", 64'(err_pulses), 64'd260);
    chk("t5_wr_pulses", 64'(wr_pulses), 64'd1);
    chk("t5_stu_kept", 64'(SYS_TIME_UPDATE), 64'd1);
    check_fields("t5");

    // 6: reset in the middle of a payload
    mk_cmd(PL, 8'h00);
    frm = frm[0:9];
    CS_N = 1'b0;
    #200;
    send_bits();
    #3 RESET = 1'b1;
    #1;
    chk("t6_freq", 64'(FREQ), 64'd0);
    chk("t6_time_start", TIME_START, 64'd0);
    chk("t6_tb2", 64'(Tblank2), 64'd0);
    chk("t6_err_cnt", 64'(ERR_CNT), 64'd0);
    chk("t6_stu", 64'(SYS_TIME_UPDATE), 64'd0);
    chk("t6_time_init", TIME_INIT, 64'd0);
    repeat (4) @(posedge CLK);
    #3 RESET = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    CS_N = 1'b1;
    settle();
    chk("t6_no_frame_err", 64'(err_pulses), 64'd260);
    chk("t6_no_wr", 64'(wr_pulses), 64'd1);
    mk_cmd(PL_T6, 8'h00);
    send_frame();
    settle();
    chk("t6_wr_pulses", 64'(wr_pulses), 64'd2);
    chk("t6_err_cnt_after", 64'(ERR_CNT), 64'd0);
    check_fields("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
